// File: rtl/mantissa_oaum_iter.sv
// Iterative approximate (1+x)(1+y) mantissa multiplier that adds one partial-product row per cycle up to level L.
// Latency is L cycles from accept. OAUM_ITER_EARLY_TERM_EN stops early once no set x bits remain.
// in_ready is high only in IDLE. The result is held until out_ready.
module mantissa_oaum_iter #(
  parameter int MANTISSA_WIDTH = 15,
  parameter int MAX_LEVEL      = 2,
  localparam int LEVEL_W       = (MAX_LEVEL < 1) ? 1 : $clog2(MAX_LEVEL + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANTISSA_WIDTH-1:0] mantissa_x,
  input  logic [MANTISSA_WIDTH-1:0] mantissa_y,
  input  logic [LEVEL_W-1:0]        level_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MANTISSA_WIDTH-1:0] mantissa_out,
  output logic [1:0]                shift
);

  localparam int W  = MANTISSA_WIDTH;
  localparam int AW = 2 * W + 2;
  localparam int CW = $clog2(W + 2);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_acc;
  logic [AW-1:0]   r_ysh;
  logic [W-1:0]    r_xsh;
  logic [W-1:0]    r_msk;
  logic [CW-1:0]   r_row;
  logic [CW-1:0]   r_lvl;

  logic [CW-1:0]   w_lvl;
  logic [W-1:0]    w_lvl_mask;
  logic [AW-1:0]   w_comp;
  logic [AW-1:0]   w_init;
  logic            w_accept;
  logic            w_any_init;
  logic            w_any_rem;
  logic            w_unused;

  always_comb begin
    if (int'(level_in) > MAX_LEVEL) w_lvl = CW'(MAX_LEVEL);
    else                            w_lvl = CW'(level_in);
  end

  // Rows 1..L live in the top L bits of x; the mask walks with x as rows retire.
  assign w_lvl_mask = ~({W{1'b1}} >> w_lvl);
  assign w_comp     = (int'(w_lvl) >= W) ? '0 : (AW'(1) << (2 * W - 2 - int'(w_lvl)));
  assign w_init     = (AW'(1) << (2 * W)) + (AW'(mantissa_x) << W)
                    + (AW'(mantissa_y) << W) + w_comp;
  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_any_init = |(mantissa_x & w_lvl_mask);
  assign w_any_rem  = |(r_xsh[W-2:0] & r_msk[W-2:0]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef OAUM_ITER_EARLY_TERM_EN
          if (w_lvl == '0 || !w_any_init) w_state_nxt = S_DONE;
          else                            w_state_nxt = S_ACCUM;
`else
          if (w_lvl == '0) w_state_nxt = S_DONE;
          else             w_state_nxt = S_ACCUM;
`endif
        end
      end
      S_ACCUM: begin
`ifdef OAUM_ITER_EARLY_TERM_EN
        if (r_row == r_lvl || !w_any_rem) w_state_nxt = S_DONE;
`else
        if (r_row == r_lvl) w_state_nxt = S_DONE;
`endif
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_ysh   <= '0;
      r_xsh   <= '0;
      r_msk   <= '0;
      r_row   <= '0;
      r_lvl   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc <= w_init;
        r_xsh <= mantissa_x;
        r_ysh <= AW'(mantissa_y) << (W - 1);
        r_msk <= w_lvl_mask;
        r_lvl <= w_lvl;
        r_row <= CW'(1);
      end else if (r_state == S_ACCUM) begin
        // Row i adds y * 2^-(W+i), i.e. y << (W-i) in accumulator units.
        if (r_xsh[W-1]) r_acc <= r_acc + r_ysh;
        r_xsh <= r_xsh << 1;
        r_msk <= r_msk << 1;
        r_ysh <= r_ysh >> 1;
        r_row <= r_row + 1'b1;
      end
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign shift        = r_acc[AW-1:AW-2];
  assign mantissa_out = shift[1] ? r_acc[2*W:W+1] : r_acc[2*W-1:W];

  assign w_unused = ^{r_acc[W-1:0], r_msk, w_any_rem, w_any_init};

endmodule

// File: tb/tb_mantissa_oaum_iter.sv
// Bench for mantissa_oaum_iter: MAX_LEVEL=2 and MAX_LEVEL=15 instances, scoreboarded transactions.
module tb_mantissa_oaum_iter;
  localparam int W = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid_a = 1'b0, in_valid_b = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  mx = '0, my = '0;
  logic [1:0]    lvl_a = '0;
  logic [3:0]    lvl_b = '0;
  logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [W-1:0]  mant_a, mant_b;
  logic [1:0]    shift_a, shift_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] q_mant[$];
  logic [1:0]   q_shift[$];
  int           q_lat[$];

  always #5 clk = ~clk;

  mantissa_oaum_iter #(.MANTISSA_WIDTH(W), .MAX_LEVEL(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .mantissa_x(mx), .mantissa_y(my), .level_in(lvl_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .mantissa_out(mant_a), .shift(shift_a)
  );

  mantissa_oaum_iter #(.MANTISSA_WIDTH(W), .MAX_LEVEL(15)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .mantissa_x(mx), .mantissa_y(my), .level_in(lvl_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .mantissa_out(mant_b), .shift(shift_b)
  );

  function automatic logic cur_ov(input bit sel);
    return sel ? out_valid_b : out_valid_a;
  endfunction
  function automatic logic cur_rdy(input bit sel);
    return sel ? in_ready_b : in_ready_a;
  endfunction
  function automatic logic [W-1:0] cur_mant(input bit sel);
    return sel ? mant_b : mant_a;
  endfunction
  function automatic logic [1:0] cur_shift(input bit sel);
    return sel ? shift_b : shift_a;
  endfunction

  // Reference value computed in real arithmetic (all terms exactly representable).
  task automatic push_model(input logic [W-1:0] x, input logic [W-1:0] y, input int lvl);
    real s, yv, p, frac;
    int  lat, sh;
    yv  = real'(y) / 32768.0;
    s   = 1.0 + real'(x) / 32768.0 + yv;
    if (lvl < W) begin
      p = 1.0;
      repeat (lvl + 2) p = p / 2.0;
      s = s + p;
    end
    p   = 1.0;
    lat = 0;
    for (int i = 1; i <= lvl; i++) begin
      p = p / 2.0;
      if (x[W-i]) begin
        s   = s + p * yv;
        lat = i;
      end
    end
`ifndef OAUM_ITER_EARLY_TERM_EN
    lat = lvl;
`endif
    sh   = $rtoi(s);
    frac = (sh >= 2) ? (s / 2.0 - 1.0) : (s - 1.0);
    q_mant.push_back(W'($rtoi(frac * 32768.0)));
    q_shift.push_back(2'(sh));
    q_lat.push_back(lat);
  endtask

  task automatic run_txn(input bit sel, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [3:0] l, input int hold, input string name);
    int           guard, lat, exp_lat;
    logic [W-1:0] exp_m;
    logic [1:0]   exp_s;
    bit           stable;
    exp_m   = q_mant.pop_front();
    exp_s   = q_shift.pop_front();
    exp_lat = q_lat.pop_front();
    guard = 0;
    @(negedge clk);
    while (!cur_rdy(sel) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL %s ready timeout: in_ready stayed 0, required 1", name);
      return;
    end
    mx = x; my = y; lvl_a = l[1:0]; lvl_b = l;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    mx = ~x; my = ~y;
    n_tests++;
    if (cur_rdy(sel) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy in_ready: got %b required 0", name, cur_rdy(sel));
    end
    lat = 0;
    while (!cur_ov(sel) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (cur_ov(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid timeout: got %b required 1", name, cur_ov(sel));
      return;
    end
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    n_tests++;
    if (cur_mant(sel) !== exp_m) begin
      n_fail++;
      $display("FAIL %s mantissa_out: got %h required %h", name, cur_mant(sel), exp_m);
    end
    n_tests++;
    if (cur_shift(sel) !== exp_s) begin
      n_fail++;
      $display("FAIL %s shift: got %b required %b", name, cur_shift(sel), exp_s);
    end
    if (hold > 0) begin
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (cur_mant(sel) !== exp_m || cur_shift(sel) !== exp_s ||
            cur_ov(sel) !== 1'b1 || cur_rdy(sel) !== 1'b0) stable = 1'b0;
      end
      n_tests++;
      if (!stable) begin
        n_fail++;
        $display("FAIL %s hold: outputs changed, got m=%h s=%b v=%b r=%b required m=%h s=%b v=1 r=0",
                 name, cur_mant(sel), cur_shift(sel), cur_ov(sel), cur_rdy(sel), exp_m, exp_s);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (cur_ov(sel) !== 1'b0 || cur_rdy(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got v=%b r=%b required v=0 r=1", name, cur_ov(sel), cur_rdy(sel));
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || mant_a !== '0 || shift_a !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_a: got r=%b v=%b m=%h s=%b required 1 0 0 0", in_ready_a, out_valid_a, mant_a, shift_a);
    end
    n_tests++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || mant_b !== '0 || shift_b !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_b: got r=%b v=%b m=%h s=%b required 1 0 0 0", in_ready_b, out_valid_b, mant_b, shift_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_level0;
    q_mant.push_back(15'h2000); q_shift.push_back(2'b01); q_lat.push_back(0);
    run_txn(1'b0, 15'h0000, 15'h0000, 4'd0, 0, "level0");
  endtask

  task automatic test_level2;
    int el;
`ifdef OAUM_ITER_EARLY_TERM_EN
    el = 1;
`else
    el = 2;
`endif
    q_mant.push_back(15'h1400); q_shift.push_back(2'b10); q_lat.push_back(el);
    run_txn(1'b0, 15'h4000, 15'h4000, 4'd2, 0, "level2");
    q_mant.push_back(15'h1400); q_shift.push_back(2'b10); q_lat.push_back(el);
    run_txn(1'b0, 15'h4000, 15'h4000, 4'd3, 0, "clamp");
  endtask

  task automatic test_exact;
    q_mant.push_back(15'h7FFE); q_shift.push_back(2'b11); q_lat.push_back(15);
    run_txn(1'b1, 15'h7FFF, 15'h7FFF, 4'd15, 0, "exact15");
  endtask

  task automatic test_hold;
    int el;
`ifdef OAUM_ITER_EARLY_TERM_EN
    el = 1;
`else
    el = 2;
`endif
    q_mant.push_back(15'h1400); q_shift.push_back(2'b10); q_lat.push_back(el);
    run_txn(1'b0, 15'h4000, 15'h4000, 4'd2, 5, "hold");
  endtask

  task automatic test_abort;
    bit seen;
    @(negedge clk);
    mx = 15'h4000; my = 15'h4000; lvl_a = 2'd2; in_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    n_tests++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || mant_a !== '0 || shift_a !== 2'b00) begin
      n_fail++;
      $display("FAIL abort: got v=%b r=%b m=%h s=%b required 0 1 0 0", out_valid_a, in_ready_a, mant_a, shift_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid_a !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_ghost: out_valid got 1 after reset, required 0");
    end
    push_model(15'h2A5C, 15'h1357, 2);
    run_txn(1'b0, 15'h2A5C, 15'h1357, 4'd2, 0, "after_abort");
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] x, y;
    int           l;
    for (int n = 0; n < 12; n++) begin
      x = W'($urandom);
      y = W'($urandom);
      l = $urandom_range(0, 15);
      push_model(x, y, l);
      run_txn(1'b1, x, y, 4'(l), 0, "rand_b");
    end
    for (int n = 0; n < 8; n++) begin
      x = W'($urandom);
      y = W'($urandom);
      l = $urandom_range(0, 3);
      push_model(x, y, (l > 2) ? 2 : l);
      run_txn(1'b0, x, y, 4'(l), 0, "rand_a");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_level0();
    test_level2();
    test_exact();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
